// File: rtl/solution_uart_tx.sv
// rtl/solution_uart_tx.sv - FIFO-buffered 8N1 UART transmitter for solution markers and leaf-index words
module solution_uart_tx #(
  parameter int         CLK_DIV  = 868,
  parameter int         FIFO_AW  = 6,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic        eclk,
  input  logic        rstb,
  input  logic        uart_start,
  input  logic [63:0] uart_tdata,
  input  logic        uart_headernonce_send,
  output logic        txd,
  output logic        tx_busy,
  output logic        overflow,
  output logic [15:0] word_cnt
);

  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // FIFO storage: {mark, has_data, data[63:0]}
  logic [65:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [65:0] wr_entry;
  logic [65:0] rd_entry;

  state_t      state;
  logic        ent_has_data;
  logic [63:0] ent_data;
  logic [2:0]  byte_idx;
  logic [3:0]  bit_idx;
  logic [15:0] bit_timer;
  logic [7:0]  cur_byte;
  logic        last_byte;

  // Count never exceeds DEPTH, so its MSB alone marks "full".
  assign full     = count[FIFO_AW];
  assign empty    = (count == '0);
  assign push_req = uart_start | uart_headernonce_send;
  assign push     = push_req & ~full;
  assign pop      = (state == ST_IDLE) & ~empty;
  assign wr_entry = {uart_headernonce_send, uart_start, uart_start ? uart_tdata : 64'h0};
  assign rd_entry = mem[rd_ptr];
  assign tx_busy  = ~empty | (state != ST_IDLE);

  // Byte being framed and whether it is the last byte of the current entry
  always_comb begin
    cur_byte  = SOF_BYTE;
    last_byte = 1'b0;
    if (state == ST_SOF) begin
      cur_byte  = SOF_BYTE;
      last_byte = ~ent_has_data;
    end else begin
      cur_byte  = ent_data[{byte_idx, 3'b000} +: 8];
      last_byte = (byte_idx == 3'd7);
    end
  end

  // FIFO array write; contents need no reset since count gates every read
  always_ff @(posedge eclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; full is judged before the same-cycle pop
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow on a dropped write and saturating accepted-word counter
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      overflow <= 1'b0;
      word_cnt <= 16'h0000;
    end else begin
      if (push_req && full) overflow <= 1'b1;
      if (push && uart_start && (word_cnt != 16'hFFFF)) word_cnt <= word_cnt + 16'd1;
    end
  end

  // Transmit FSM with integrated byte framer; bytes inside an entry run back to back
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      state        <= ST_IDLE;
      ent_has_data <= 1'b0;
      ent_data     <= 64'h0;
      byte_idx     <= 3'd0;
      bit_idx      <= 4'd0;
      bit_timer    <= 16'd0;
      txd          <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            ent_has_data <= rd_entry[64];
            ent_data     <= rd_entry[63:0];
            byte_idx     <= 3'd0;
            bit_idx      <= 4'd0;
            bit_timer    <= 16'd0;
            txd          <= 1'b0;
            state        <= rd_entry[65] ? ST_SOF : ST_DATA;
          end
        end
        ST_SOF, ST_DATA: begin
          if (bit_timer != DIV_LAST) begin
            bit_timer <= bit_timer + 16'd1;
          end else begin
            bit_timer <= 16'd0;
            if (bit_idx != 4'd9) begin
              bit_idx <= bit_idx + 4'd1;
              txd     <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
            end else begin
              bit_idx <= 4'd0;
              if (last_byte) begin
                state <= ST_IDLE;
                txd   <= 1'b1;
              end else begin
                txd <= 1'b0;
                if (state == ST_SOF) begin
                  state    <= ST_DATA;
                  byte_idx <= 3'd0;
                end else begin
                  byte_idx <= byte_idx + 3'd1;
                end
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solution_uart_tx.sv
// tb/tb_solution_uart_tx.sv - self-checking bench for solution_uart_tx
module tb_solution_uart_tx;

  localparam int DIV = 4;
  localparam int AW  = 2;
  localparam int DEP = 1 << AW;
  localparam int FRAME = 10 * DIV;

  logic        eclk = 1'b0;
  logic        rstb = 1'b0;
  logic        uart_start = 1'b0;
  logic [63:0] uart_tdata = 64'h0;
  logic        uart_headernonce_send = 1'b0;
  logic        txd;
  logic        tx_busy;
  logic        overflow;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  int         mon_frame_err = 0;
  bit         mon_active = 0;
  int         mon_cnt = 0;
  int         mon_sc = 0;
  logic [7:0] mon_sh = 8'h00;

  solution_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW), .SOF_BYTE(8'hA5)) dut (
    .eclk(eclk),
    .rstb(rstb),
    .uart_start(uart_start),
    .uart_tdata(uart_tdata),
    .uart_headernonce_send(uart_headernonce_send),
    .txd(txd),
    .tx_busy(tx_busy),
    .overflow(overflow),
    .word_cnt(word_cnt)
  );

  initial forever #5 eclk = ~eclk;

  initial forever begin
    @(posedge eclk);
    cyc = cyc + 1;
  end

  // Line monitor: decode 8N1 frames by mid-bit sampling, recording each frame's first low cycle
  initial forever begin
    @(negedge eclk);
    if (!rstb) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        mon_sc = cyc;
        mon_sh = 8'h00;
      end
    end else begin
      mon_cnt = mon_cnt + 1;
      if (mon_cnt >= DIV + DIV/2 && mon_cnt <= 8*DIV + DIV/2 && (mon_cnt % DIV) == DIV/2)
        mon_sh[(mon_cnt - DIV - DIV/2) / DIV] = txd;
      if (mon_cnt == 9*DIV + DIV/2 && txd !== 1'b1) mon_frame_err = mon_frame_err + 1;
      if (mon_cnt == FRAME - 1) begin
        mon_bytes.push_back(mon_sh);
        mon_starts.push_back(mon_sc);
        mon_active = 0;
      end
    end
  end

  task automatic drive(input logic m, input logic s, input logic [63:0] d, output int t);
    @(posedge eclk);
    #1;
    uart_headernonce_send = m;
    uart_start = s;
    uart_tdata = d;
    t = cyc;
  endtask

  task automatic idle(input int n);
    int t;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'h0, t);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(posedge eclk);
    @(negedge eclk);
  endtask

  task automatic do_reset();
    #1;
    rstb = 1'b0;
    uart_start = 1'b0;
    uart_headernonce_send = 1'b0;
    repeat (3) @(posedge eclk);
    #1;
    rstb = 1'b1;
    mon_bytes.delete();
    mon_starts.delete();
    mon_frame_err = 0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge eclk);
      #1;
      uart_start = 1'($urandom);
      uart_headernonce_send = 1'($urandom);
      uart_tdata = {$urandom, $urandom};
    end
    @(negedge eclk);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b exp 1", txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", tx_busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_wcnt: got %h exp 0", word_cnt); end
    uart_start = 1'b0;
    uart_headernonce_send = 1'b0;
    #1 rstb = 1'b1;
    mon_bytes.delete();
    mon_starts.delete();
    idle(100);
    @(negedge eclk);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL idle_txd: got %b exp 1", txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", tx_busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL idle_ovf: got %b exp 0", overflow); end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL idle_wcnt: got %h exp 0", word_cnt); end
    n_checks++; if (mon_bytes.size() !== 0) begin n_fail++; $display("FAIL idle_bytes: got %0d exp 0", mon_bytes.size()); end
  endtask

  task automatic test_marker();
    int t;
    do_reset();
    idle(3);
    drive(1'b1, 1'b0, 64'h0, t);
    idle(1);
    wait_cycle(t + 1);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL mark_t1_txd: got %b exp 1", txd); end
    wait_cycle(t + 2);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL mark_t2_txd: got %b exp 0", txd); end
    wait_cycle(t + 41);
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL mark_busy41: got %b exp 1", tx_busy); end
    wait_cycle(t + 42);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mark_busy42: got %b exp 0", tx_busy); end
    idle(20);
    n_checks++;
    if (mon_bytes.size() !== 1) begin
      n_fail++; $display("FAIL mark_nbytes: got %0d exp 1", mon_bytes.size());
    end else begin
      n_checks++; if (mon_bytes[0] !== 8'hA5) begin n_fail++; $display("FAIL mark_byte: got %h exp a5", mon_bytes[0]); end
      n_checks++; if (mon_starts[0] !== t + 2) begin n_fail++; $display("FAIL mark_start: got %0d exp %0d", mon_starts[0], t + 2); end
    end
    n_checks++; if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL mark_wcnt: got %h exp 0", word_cnt); end
    n_checks++; if (mon_frame_err !== 0) begin n_fail++; $display("FAIL mark_stop: got %0d exp 0", mon_frame_err); end
  endtask

  // Expected bytes are data bytes LSB first, optionally led by the marker byte; frames contiguous from t+2
  task automatic check_entry(input string name, input int t, input logic m, input logic [63:0] d);
    logic [7:0] exp_b[$];
    if (m) exp_b.push_back(8'hA5);
    for (int j = 0; j < 8; j++) exp_b.push_back(8'((d >> (8 * j)) & 64'hFF));
    for (int k = 0; k < 2000 && mon_bytes.size() < exp_b.size(); k++) @(posedge eclk);
    idle(4);
    n_checks++;
    if (mon_bytes.size() !== exp_b.size()) begin
      n_fail++; $display("FAIL %s_nbytes: got %0d exp %0d", name, mon_bytes.size(), exp_b.size());
    end else begin
      for (int j = 0; j < exp_b.size(); j++) begin
        n_checks++; if (mon_bytes[j] !== exp_b[j]) begin n_fail++; $display("FAIL %s_byte%0d: got %h exp %h", name, j, mon_bytes[j], exp_b[j]); end
        n_checks++; if (mon_starts[j] !== t + 2 + FRAME * j) begin n_fail++; $display("FAIL %s_start%0d: got %0d exp %0d", name, j, mon_starts[j], t + 2 + FRAME * j); end
      end
    end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b exp 0", name, tx_busy); end
  endtask

  task automatic test_data_word();
    int t;
    do_reset();
    drive(1'b0, 1'b1, 64'h0011223344556677, t);
    idle(1);
    check_entry("data", t, 1'b0, 64'h0011223344556677);
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL data_wcnt: got %0d exp 1", word_cnt); end
  endtask

  task automatic test_marker_and_data();
    int t;
    do_reset();
    drive(1'b1, 1'b1, 64'h0000000100000002, t);
    idle(1);
    check_entry("both", t, 1'b1, 64'h0000000100000002);
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL both_wcnt: got %0d exp 1", word_cnt); end
  endtask

  task automatic test_overflow();
    int t;
    logic [63:0] w[6];
    do_reset();
    for (int i = 0; i < 6; i++) w[i] = {10'h0, 22'($urandom), 10'h0, 22'($urandom)};
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, w[i], t);
    idle(1);
    @(negedge eclk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    n_checks++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL ovf_wcnt: got %0d exp 5", word_cnt); end
    for (int k = 0; k < 3000 && tx_busy; k++) @(posedge eclk);
    idle(100);
    n_checks++;
    if (mon_bytes.size() !== 40) begin
      n_fail++; $display("FAIL ovf_nbytes: got %0d exp 40", mon_bytes.size());
    end else begin
      for (int j = 0; j < 40; j++) begin
        n_checks++;
        if (mon_bytes[j] !== 8'((w[j / 8] >> (8 * (j % 8))) & 64'hFF)) begin
          n_fail++; $display("FAIL ovf_byte%0d: got %h exp %h", j, mon_bytes[j], 8'((w[j / 8] >> (8 * (j % 8))) & 64'hFF));
        end
      end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    do_reset();
    drive(1'b0, 1'b1, 64'h0011223344556677, t);
    idle(1);
    wait_cycle(t + 2 + FRAME + 1);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_txd: got %b exp 0", txd); end
    #1 rstb = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b exp 1", txd); end
    repeat (3) @(posedge eclk);
    #1 rstb = 1'b1;
    mon_bytes.delete();
    mon_starts.delete();
    idle(400);
    @(negedge eclk);
    n_checks++; if (mon_bytes.size() !== 0) begin n_fail++; $display("FAIL midrst_bytes: got %0d exp 0", mon_bytes.size()); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", tx_busy); end
    n_checks++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_wcnt: got %0d exp 0", word_cnt); end
  endtask

  // Random traffic against a timing model: each entry is popped one cycle after arrival or
  // one cycle after the previous entry's last stop bit, whichever is later; writes are
  // dropped when DEP accepted entries are still awaiting their pop cycle.
  task automatic test_random();
    int t;
    int pops[$];
    int next_free;
    int occ;
    int p;
    int nb;
    int last_end;
    int exp_wcnt;
    logic exp_ovf;
    logic m;
    logic s;
    int kind;
    logic [63:0] d;
    logic [7:0] exp_b[$];
    int exp_s[$];
    do_reset();
    next_free = 0;
    last_end = 0;
    exp_wcnt = 0;
    exp_ovf = 1'b0;
    for (int e = 0; e < 16; e++) begin
      idle($urandom_range(0, 70));
      kind = $urandom_range(1, 3);
      m = kind[0];
      s = kind[1];
      d = {10'h0, 22'($urandom), 10'h0, 22'($urandom)};
      drive(m, s, d, t);
      occ = 0;
      foreach (pops[i]) if (pops[i] >= t) occ++;
      if (occ >= DEP) begin
        exp_ovf = 1'b1;
      end else begin
        p = (t + 1 > next_free) ? t + 1 : next_free;
        nb = (m ? 1 : 0) + (s ? 8 : 0);
        pops.push_back(p);
        next_free = p + FRAME * nb + 1;
        last_end = next_free;
        if (s) exp_wcnt++;
        for (int j = 0; j < nb; j++) exp_s.push_back(p + 1 + FRAME * j);
        if (m) exp_b.push_back(8'hA5);
        if (s) for (int j = 0; j < 8; j++) exp_b.push_back(8'((d >> (8 * j)) & 64'hFF));
      end
    end
    idle(1);
    wait_cycle(last_end + 5);
    n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL rnd_ovf: got %b exp %b", overflow, exp_ovf); end
    n_checks++; if (word_cnt !== 16'(exp_wcnt)) begin n_fail++; $display("FAIL rnd_wcnt: got %0d exp %0d", word_cnt, exp_wcnt); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy: got %b exp 0", tx_busy); end
    n_checks++; if (mon_frame_err !== 0) begin n_fail++; $display("FAIL rnd_stop: got %0d exp 0", mon_frame_err); end
    n_checks++;
    if (mon_bytes.size() !== exp_b.size()) begin
      n_fail++; $display("FAIL rnd_nbytes: got %0d exp %0d", mon_bytes.size(), exp_b.size());
    end else begin
      for (int j = 0; j < exp_b.size(); j++) begin
        n_checks++; if (mon_bytes[j] !== exp_b[j]) begin n_fail++; $display("FAIL rnd_byte%0d: got %h exp %h", j, mon_bytes[j], exp_b[j]); end
        n_checks++; if (mon_starts[j] !== exp_s[j]) begin n_fail++; $display("FAIL rnd_start%0d: got %0d exp %0d", j, mon_starts[j], exp_s[j]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_marker();
    test_data_word();
    test_marker_and_data();
    test_overflow();
    test_reset_mid_frame();
    for (int r = 0; r < 3; r++) test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
